serial_frame_transmitter: RTL and testbench

//   Response-path framer and UART transmitter for the serial command link (the other direction of the frame rx path).

---
 rtl/serial_frame_transmitter.sv | 179 +++++++++++++++++
 tb/tb_serial_frame_transmitter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_transmitter.sv
// Buffers a payload and sends SOF SOF SPACE LEN PAYLOAD EOF EOF as 8E1 UART bytes; tx falls 2 clocks after the last payload handshake.
// pl_ready is low from that handshake until done; host_ready low stalls only before a start bit, never mid-byte.
module serial_frame_transmitter #(
   parameter int         CLK_FREQ    = 50000000,
   parameter int         BAUD_RATE   = 115200,
   parameter int         MAX_PAYLOAD = 16,
   parameter int         GAP_BITS    = 1,
   parameter logic [7:0] SOF_BYTE    = 8'hFF,
   parameter logic [7:0] SPACE_BYTE  = 8'h00,
   parameter logic [7:0] EOF_BYTE    = 8'hEE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pl_data,
   input  logic       pl_valid,
   input  logic       pl_last,
   output logic       pl_ready,
   input  logic       host_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
   localparam int GAP_TICKS = GAP_BITS * BIT_TICKS;
   localparam int MAX_TICKS = (GAP_TICKS > BIT_TICKS) ? GAP_TICKS : BIT_TICKS;
   localparam int TW        = $clog2(MAX_TICKS + 1);
   localparam int AW        = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT_HOST, S_SHIFT, S_GAP, S_DONE} state_t;

   state_t          r_state;
   logic [7:0]      r_buf [0:(2**AW)-1];
   logic [7:0]      r_cnt;
   logic [7:0]      r_len;
   logic [8:0]      r_idx;
   logic [TW-1:0]   r_tick;
   logic [3:0]      r_bit;
   logic [10:0]     r_frame;
   logic            r_launch;
   logic            r_tx;
   logic            r_busy;
   logic            r_done;
   logic            r_pl_ready;

   logic [7:0]      w_byte;
   logic [AW-1:0]   w_pidx;
   logic            w_wr;
   logic            w_tick_end_bit;
   logic            w_tick_end_gap;
   logic            w_byte_end;
   logic            w_frame_end;
   logic            w_slot_free;
   logic            w_start;

   assign tx       = r_tx;
   assign busy     = r_busy;
   assign done     = r_done;
   assign pl_ready = r_pl_ready;

   assign w_wr           = (r_state == S_IDLE) && !r_launch && pl_valid && r_pl_ready;
   assign w_pidx         = AW'(r_idx - 9'd4);
   assign w_tick_end_bit = (r_tick == TW'(BIT_TICKS - 1));
   assign w_tick_end_gap = (r_tick == TW'(GAP_TICKS - 1));
   assign w_byte_end     = (r_state == S_SHIFT) && w_tick_end_bit && (r_bit == 4'd10);
   assign w_frame_end    = w_byte_end && (r_idx == ({1'b0, r_len} + 9'd6));

   // r_idx already points at the next byte, so the stop-bit end of a non-final byte can start the next one directly.
   assign w_slot_free = (r_state == S_WAIT_HOST)
                     || ((r_state == S_GAP) && w_tick_end_gap)
                     || (w_byte_end && !w_frame_end && (GAP_TICKS == 0));
   assign w_start     = w_slot_free && host_ready;

   always_comb begin
      w_byte = EOF_BYTE;
      if (r_idx < 9'd2)
         w_byte = SOF_BYTE;
      else if (r_idx == 9'd2)
         w_byte = SPACE_BYTE;
      else if (r_idx == 9'd3)
         w_byte = r_len;
      else if (r_idx < ({1'b0, r_len} + 9'd4))
         w_byte = r_buf[w_pidx];
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_buf[r_cnt[AW-1:0]] <= pl_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_tick     <= '0;
         r_bit      <= '0;
         r_frame    <= '1;
         r_launch   <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pl_ready <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_launch) begin
                  r_launch <= 1'b0;
                  r_idx    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_WAIT_HOST;
               end else begin
                  r_pl_ready <= 1'b1;
                  if (w_wr) begin
                     r_cnt <= r_cnt + 8'd1;
                     if (pl_last || (r_cnt == 8'(MAX_PAYLOAD - 1))) begin
                        r_len      <= r_cnt + 8'd1;
                        r_launch   <= 1'b1;
                        r_pl_ready <= 1'b0;
                     end
                  end
               end
            end
            S_WAIT_HOST: begin
               r_tx <= 1'b1;
            end
            S_SHIFT: begin
               if (w_tick_end_bit) begin
                  r_tick <= '0;
                  if (r_bit == 4'd10) begin
                     r_bit <= '0;
                     if (w_frame_end) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                     end else if (GAP_TICKS > 0) begin
                        r_state <= S_GAP;
                     end else begin
                        r_state <= S_WAIT_HOST;
                     end
                  end else begin
                     r_bit   <= r_bit + 4'd1;
                     r_tx    <= r_frame[1];
                     r_frame <= {1'b1, r_frame[10:1]};
                  end
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            S_GAP: begin
               if (w_tick_end_gap) begin
                  r_tick  <= '0;
                  r_state <= S_WAIT_HOST;
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            S_DONE: begin
               r_pl_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_start) begin
            r_frame <= {1'b1, ^w_byte, w_byte, 1'b0};
            r_tx    <= 1'b0;
            r_idx   <= r_idx + 9'd1;
            r_tick  <= '0;
            r_bit   <= '0;
            r_state <= S_SHIFT;
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Scoreboard bench for serial_frame_transmitter at 10 clocks per bit: stimulus queues expected line words,
// independent monitors decode tx and check bytes, slot widths and start-to-done duration.
module tb_serial_frame_transmitter;

   localparam int BT  = 10;
   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pl_data = 8'h00;
   logic       pl_valid = 1'b0;
   logic       pl_last = 1'b0;
   logic       host_ready = 1'b1;
   logic       pl_ready;
   logic       tx;
   logic       busy;
   logic       done;

   serial_frame_transmitter #(
      .CLK_FREQ   (50000000),
      .BAUD_RATE  (5000000),
      .MAX_PAYLOAD(16),
      .GAP_BITS   (GAP),
      .SOF_BYTE   (8'hFF),
      .SPACE_BYTE (8'h00),
      .EOF_BYTE   (8'hEE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pl_data   (pl_data),
      .pl_valid  (pl_valid),
      .pl_last   (pl_last),
      .pl_ready  (pl_ready),
      .host_ready(host_ready),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [10:0] word;
      bit          first;
   } exp_t;

   exp_t exp_q[$];
   int   dur_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   bytes_seen = 0;
   int   done_seen = 0;
   int   t_first = 0;
   int   last_hs = 0;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [10:0] mkword(input logic [7:0] d, input logic p);
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic push_word(input logic [7:0] d, input logic p, input bit first);
      exp_t e;
      e.word  = mkword(d, p);
      e.first = first;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [7:0] pl[$]);
      logic [7:0] b[$];
      b = {8'hFF, 8'hFF, 8'h00, 8'(pl.size())};
      foreach (pl[i]) b.push_back(pl[i]);
      b.push_back(8'hEE);
      b.push_back(8'hEE);
      foreach (b[i]) push_word(b[i], ^b[i], (i == 0));
   endtask

   function automatic int frame_dur(input int len);
      return ((len + 6) * 11 + (len + 5) * GAP) * BT;
   endfunction

   task automatic send(input logic [7:0] d, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      pl_data  = d;
      pl_valid = 1'b1;
      pl_last  = last;
      while (!pl_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check(1'b0, "pl_ready timeout", 0, 1);
      @(posedge clk);
      #1;
      last_hs  = cyc;
      pl_valid = 1'b0;
      pl_last  = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_seen < target && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check(done_seen >= target, "done pulse count", done_seen, target);
   endtask

   task automatic wait_bytes(input int target);
      int n;
      n = 0;
      while (bytes_seen < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(bytes_seen >= target, "byte start count", bytes_seen, target);
   endtask

   // Line monitor: samples every negedge of each slot, so a slot of the wrong length shows up as a glitch or a bad word.
   initial begin : byte_mon
      logic [10:0] word;
      bit          glitch;
      bit          abort;
      int          st;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            st = cyc;
            bytes_seen++;
            word   = '0;
            glitch = 1'b0;
            abort  = 1'b0;
            for (int k = 0; k < 11 && !abort; k++) begin
               for (int j = 0; j < BT && !abort; j++) begin
                  if (k != 0 || j != 0) @(negedge clk);
                  if (rst) abort = 1'b1;
                  else if (j == 0) word[k] = tx;
                  else if (tx !== word[k]) glitch = 1'b1;
               end
            end
            if (!abort) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected tx byte", {21'd0, word}, 0);
               end else begin
                  e = exp_q.pop_front();
                  if (e.first) t_first = st;
                  check(word == e.word && !glitch, "tx byte word", {20'd0, glitch, word}, {21'd0, e.word});
               end
            end
         end
      end
   end

   initial begin : done_mon
      int d;
      forever begin
         @(negedge clk);
         if (!rst && done === 1'b1) begin
            done_seen++;
            if (dur_q.size() == 0) begin
               check(1'b0, "unexpected done", 1, 0);
            end else begin
               d = dur_q.pop_front();
               if (d >= 0) check(cyc - t_first == d, "start-to-done clocks", cyc - t_first, d);
            end
         end
      end
   end

   initial begin : stim
      logic [7:0] t1_b [8];
      logic       t1_p [8];
      logic [7:0] pl[$];
      int         base;
      int         bad;
      int         d0;

      // reset state
      repeat (3) @(negedge clk);
      check(tx == 1'b1, "reset tx", tx, 1);
      check(busy == 1'b0, "reset busy", busy, 0);
      check(done == 1'b0, "reset done", done, 0);
      check(pl_ready == 1'b0, "reset pl_ready", pl_ready, 0);
      rst = 1'b0;

      // T1: {02,03}, hand-computed bytes and parity
      t1_b = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h03, 8'hEE, 8'hEE};
      t1_p = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) push_word(t1_b[i], t1_p[i], (i == 0));
      dur_q.push_back(950);
      send(8'h02, 1'b0);
      send(8'h03, 1'b1);
      check(pl_ready == 1'b0, "pl_ready after last", pl_ready, 0);
      @(negedge clk);
      @(negedge clk);
      check(tx == 1'b1 && busy == 1'b1, "tx idle one clk after last", {busy, tx}, 2'b11);
      @(negedge clk);
      check(tx == 1'b0, "tx start two clks after last", tx, 0);
      wait_done(1);

      // T2 + T5: single byte 0x80, then pl_valid pulses while busy
      pl = {8'h80};
      push_frame(pl);
      dur_q.push_back(frame_dur(1));
      send(8'h80, 1'b1);
      repeat (3) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         pl_valid = i[0];
         pl_data  = 8'h77;
         pl_last  = i[1];
         if (pl_ready !== 1'b0 || busy !== 1'b1) bad++;
      end
      pl_valid = 1'b0;
      pl_last  = 1'b0;
      check(bad == 0, "pl_ready low while busy", bad, 0);
      wait_done(2);

      // T3: 16 bytes without pl_last
      pl = {};
      for (int i = 0; i < 16; i++) pl.push_back(8'(i));
      push_frame(pl);
      dur_q.push_back(frame_dur(16));
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
      check(pl_ready == 1'b0, "pl_ready drop at full buffer", pl_ready, 0);
      wait_done(3);

      // T4: host_ready stalls before the frame and before the 4th byte
      host_ready = 1'b0;
      pl = {8'h5A, 8'hA5};
      push_frame(pl);
      dur_q.push_back(-1);
      base = bytes_seen;
      send(8'h5A, 1'b0);
      send(8'hA5, 1'b1);
      bad = 0;
      repeat (5000) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      check(bad == 0 && bytes_seen == base, "tx held while host not ready", bad, 0);
      host_ready = 1'b1;
      wait_bytes(base + 3);
      repeat (30) @(negedge clk);
      host_ready = 1'b0;
      repeat (300) @(negedge clk);
      check(bytes_seen == base + 3 && tx == 1'b1, "4th byte waits for host", bytes_seen - base, 3);
      host_ready = 1'b1;
      wait_done(4);

      // T6: reset during a payload byte
      pl = {8'h11, 8'h22, 8'h33};
      push_frame(pl);
      dur_q.push_back(-1);
      base = bytes_seen;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b1);
      wait_bytes(base + 5);
      repeat (20) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check(tx == 1'b1 && busy == 1'b0 && done == 1'b0, "async reset outputs", {done, busy, tx}, 3'b001);
      exp_q.delete();
      dur_q.delete();
      d0 = done_seen;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check(done_seen == d0, "no done after abort", done_seen, d0);
      pl = {8'hC3};
      push_frame(pl);
      dur_q.push_back(frame_dur(1));
      send(8'hC3, 1'b1);
      wait_done(d0 + 1);
      repeat (20) @(negedge clk);
      check(exp_q.size() == 0, "scoreboard drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
